// File: rtl/btn_debounce_pkg.sv
// Shared constants and configuration check helper for the push-button debouncer.
package btn_debounce_pkg;

  localparam int CNT_W = 8;

  function automatic bit stable_cnt_ok(input int n);
    return (n >= 1) && (n <= 255);
  endfunction

endpackage

// File: rtl/btn_db_chan.sv
// One debounce channel: 2-flop synchroniser, tick-qualified stability counter, level and edge pulses.
// Output latency is 1 clk after the adopting tick; no backpressure, pulses are one cycle wide.
module btn_db_chan
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      // Any sample agreeing with the current level restarts qualification.
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d   = sync2_q;
        cnt_d     = '0;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Button conditioning: rising-edge detect on the rate tick feeding WIDTH independent debounce channels.
// Outputs registered, 1 clk after the adopting tick; no backpressure.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rtg_in,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  localparam bit STABLE_CNT_OK = stable_cnt_ok(STABLE_CNT);

  generate
    if (!STABLE_CNT_OK) begin : g_bad_cfg
      $error("btn_debounce: STABLE_CNT must be in 1..255");
    end
  endgenerate

  logic rtg_q, rtg_d;
  logic tick;

  always_comb begin
    rtg_d = rtg_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtg_q <= 1'b0;
    end else begin
      rtg_q <= rtg_d;
    end
  end

  // Only the rising edge counts, so a wide rate level yields a single tick.
  assign tick = rtg_in & ~rtg_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    btn_db_chan #(
      .STABLE_CNT (STABLE_CNT)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scenario bench for btn_debounce: expected pulse events are queued at stimulus time and matched
// against pulse events captured from the DUT, tagged with the rate-tick index they follow.
module tb_btn_debounce;

  localparam int WIDTH      = 4;
  localparam int STABLE_CNT = 4;

  typedef struct packed {
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  level;
    logic [31:0] tick;
  } evt_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rtg_in = 1'b0;
  logic [WIDTH-1:0] btn_raw = '0;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned tick_idx = 0;
  int unsigned phase = 0;
  bit          square = 1'b0;
  bit          square_req = 1'b0;
  logic        rtg_prev = 1'b0;
  evt_t        exp_q[$];
  evt_t        act_q[$];

  btn_debounce #(
    .WIDTH      (WIDTH),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rtg_in      (rtg_in),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  // Rate generator: period 16 clk, either a 1-cycle pulse or a 50% square wave.
  always @(posedge clk) begin
    if (rtg_in && !rtg_prev) tick_idx++;
    rtg_prev = rtg_in;
    #1;
    phase = (phase + 1) % 16;
    if (phase == 0) square = square_req;
    rtg_in = square ? (phase < 8) : (phase == 0);
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (btn_press !== '0 || btn_release !== '0))
      act_q.push_back('{press: btn_press, rel: btn_release, level: btn_level, tick: tick_idx});
  end

  task automatic sync_to_tick();
    int unsigned start = tick_idx;
    int n = 0;
    while (tick_idx == start && n < 64) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (tick_idx == start) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_wait: no rate tick within %0d cycles", n);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) sync_to_tick();
  endtask

  task automatic push_exp(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l, input int unsigned t);
    exp_q.push_back('{press: p, rel: r, level: l, tick: t});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_raw = '0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (btn_level !== 4'b0000) begin
      miscompares++; $display("FAIL reset_level: got %b want 0000", btn_level);
    end
    vectors++;
    if (btn_press !== 4'b0000) begin
      miscompares++; $display("FAIL reset_press: got %b want 0000", btn_press);
    end
    vectors++;
    if (btn_release !== 4'b0000) begin
      miscompares++; $display("FAIL reset_release: got %b want 0000", btn_release);
    end
    sync_to_tick();
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    evt_t e, a;
    sync_to_tick();
    btn_raw = 4'b0001;
    push_exp(4'b0001, 4'b0000, 4'b0001, tick_idx + 4);
    wait_ticks(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (act_q.size() == 0) begin
        miscompares++; $display("FAIL clean_press: no event, want %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin miscompares++; $display("FAIL clean_press: got %h want %h", a, e); end
      end
    end
    vectors++;
    if (act_q.size() != 0) begin
      miscompares++; $display("FAIL clean_press_extra: got %0d extra events want 0", act_q.size()); act_q.delete();
    end
    vectors++;
    if (btn_level !== 4'b0001) begin
      miscompares++; $display("FAIL clean_press_level: got %b want 0001", btn_level);
    end
  endtask

  task automatic test_bounce();
    evt_t e, a;
    int unsigned t0;
    sync_to_tick();
    t0 = tick_idx;
    btn_raw = 4'b0011;
    wait_ticks(3);
    btn_raw = 4'b0001;
    sync_to_tick();
    btn_raw = 4'b0011;
    push_exp(4'b0010, 4'b0000, 4'b0011, t0 + 8);
    wait_ticks(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (act_q.size() == 0) begin
        miscompares++; $display("FAIL bounce: no event, want %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin miscompares++; $display("FAIL bounce: got %h want %h", a, e); end
      end
    end
    vectors++;
    if (act_q.size() != 0) begin
      miscompares++; $display("FAIL bounce_extra: got %0d extra events want 0", act_q.size()); act_q.delete();
    end
  endtask

  task automatic test_release_simul(input bit wide);
    evt_t e, a;
    square_req = wide;
    wait_ticks(2);
    if (wide) begin
      btn_raw = 4'b0011;
      push_exp(4'b0011, 4'b0000, 4'b0011, tick_idx + 4);
      wait_ticks(5);
    end
    btn_raw = 4'b0000;
    push_exp(4'b0000, 4'b0011, 4'b0000, tick_idx + 4);
    wait_ticks(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (act_q.size() == 0) begin
        miscompares++; $display("FAIL release_simul(wide=%0d): no event, want %h", wide, e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin miscompares++; $display("FAIL release_simul(wide=%0d): got %h want %h", wide, a, e); end
      end
    end
    vectors++;
    if (act_q.size() != 0) begin
      miscompares++; $display("FAIL release_extra(wide=%0d): got %0d extra events want 0", wide, act_q.size()); act_q.delete();
    end
    square_req = 1'b0;
    wait_ticks(2);
  endtask

  task automatic test_glitch();
    sync_to_tick();
    repeat (5) @(posedge clk);
    #2;
    btn_raw = 4'b0100;
    @(posedge clk);
    #2;
    btn_raw = 4'b0000;
    wait_ticks(6);
    vectors++;
    if (act_q.size() != 0) begin
      miscompares++; $display("FAIL glitch_pulse: got %0d events want 0", act_q.size()); act_q.delete();
    end
    vectors++;
    if (btn_level !== 4'b0000) begin
      miscompares++; $display("FAIL glitch_level: got %b want 0000", btn_level);
    end
  endtask

  task automatic test_reset_mid();
    evt_t e, a;
    sync_to_tick();
    btn_raw = 4'b0001;
    push_exp(4'b0001, 4'b0000, 4'b0001, tick_idx + 4);
    wait_ticks(5);
    btn_raw = 4'b1001;
    wait_ticks(2);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (btn_level !== 4'b0000) begin
      miscompares++; $display("FAIL mid_reset_level: got %b want 0000", btn_level);
    end
    vectors++;
    if ((btn_press | btn_release) !== 4'b0000) begin
      miscompares++; $display("FAIL mid_reset_pulse: got press=%b rel=%b want 0", btn_press, btn_release);
    end
    repeat (20) @(posedge clk);
    sync_to_tick();
    rst_n = 1'b1;
    push_exp(4'b1001, 4'b0000, 4'b1001, tick_idx + 4);
    wait_ticks(5);
    btn_raw = 4'b0000;
    push_exp(4'b0000, 4'b1001, 4'b0000, tick_idx + 4);
    wait_ticks(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (act_q.size() == 0) begin
        miscompares++; $display("FAIL reset_mid: no event, want %h", e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin miscompares++; $display("FAIL reset_mid: got %h want %h", a, e); end
      end
    end
    vectors++;
    if (act_q.size() != 0) begin
      miscompares++; $display("FAIL reset_mid_extra: got %0d extra events want 0", act_q.size()); act_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_simul(1'b0);
    test_release_simul(1'b1);
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Push-button conditioning stage directly downstream of the rate generator.
- Consumes the generator's slow rate output as a sampling tick.
- Synchronises WIDTH raw button inputs and debounces each by requiring STABLE_CNT consecutive agreeing tick samples.
- Produces clean levels plus one-cycle press/release pulses for the control logic.

Parameters:
- WIDTH, 4: number of independent button channels.
- STABLE_CNT, 4: consecutive ticks a new input level must persist before it is adopted; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rtg_in  input  1  rate tick from the rate generator; only its rising edge is used.
- btn_raw  input  WIDTH  raw, asynchronous, active-high button inputs.
- btn_level  output  WIDTH  debounced button level.
- btn_press  output  WIDTH  one-cycle pulse on a debounced 0->1 transition.
- btn_release  output  WIDTH  one-cycle pulse on a debounced 1->0 transition.

Behaviour:
- Reset: asynchronous assert, synchronous release (rst_n). All state clears to 0: synchroniser flops, rtg_q, counters, btn_level, btn_press, btn_release.
- Tick detect:
  - rtg_q is rtg_in registered once.
  - tick = rtg_in & ~rtg_q.
  - tick is high for exactly one clk cycle per rising edge of rtg_in, whether rtg_in is a one-cycle spike or a wide level.
  - If rtg_in is already high when reset releases, one tick occurs in the first cycle.
- Synchroniser: btn_raw[i] passes through 2 flops to give sync[i]. No other logic uses btn_raw.
- Per-channel counter cnt[i] is 8 bits. All outputs are registered.
- Per-channel update, evaluated only on cycles with tick = 1:
  - sync == btn_level: cnt <= 0 (any agreeing sample restarts qualification).
  - sync != btn_level and cnt == STABLE_CNT-1: btn_level <= sync; cnt <= 0; same edge, btn_press <= sync and btn_release <= ~sync.
  - Otherwise: cnt <= cnt + 1.
- Non-tick cycles: cnt and btn_level hold. btn_press and btn_release return to 0.
- btn_press/btn_release:
  - High exactly one clk cycle, coincident with the first cycle btn_level shows its new value.
  - Never both high on the same channel.
- STABLE_CNT = 1: a change is adopted on the first disagreeing tick.
- Latency from a clean btn_raw edge:
  - 2 clk cycles for synchronisation, then adoption on the STABLE_CNT-th tick whose sampled sync disagrees.
  - btn_level and pulse appear 1 clk after that tick cycle.
- Counter never exceeds STABLE_CNT-1, so no wrap-around is possible.
- Channels are fully independent. Simultaneous adoptions on several channels in the same tick are legal and produce simultaneous pulses.
- Reset mid-qualification: partially counted progress is discarded, btn_level returns to 0, and no pulse is emitted for the reset itself.
- A button held high through reset release is re-qualified from scratch. A press pulse follows after STABLE_CNT ticks.

Decomposition:
- Shared package: constant CNT_W = 8, and a localparam check that 1 <= STABLE_CNT <= 255.
- One sub-module, btn_db_chan, holds the per-channel logic: synchroniser, counter, level/pulse registers, with tick as input.
- btn_debounce contains the tick edge detect and a generate loop of WIDTH btn_db_chan instances.

Test Plan:
- Common setup for all scenarios: WIDTH=4, STABLE_CNT=4; rtg_in is a 1-cycle pulse every 16 clk.
- Clean press: btn_raw = 4'b0001 held.
  -> btn_level[0] rises 1 clk after the 4th tick that samples sync = 1.
  -> btn_press = 4'b0001 for exactly 1 cycle; btn_release stays 0.
- Bounce: btn_raw[1] high for 3 ticks, low for 1 tick, then high.
  -> No change until 4 further consecutive high ticks; exactly one btn_press[1] pulse.
- Release, simultaneity and wide tick: from btn_level = 4'b0011, drop both inputs in the same cycle.
  -> btn_release = 4'b0011 in one cycle after 4 ticks; btn_press stays 0.
  -> Repeat with rtg_in as a 50% square wave: adoption timing is identical, counted on rising edges only.
- Glitch rejection: 1-cycle btn_raw[2] pulse placed between ticks.
  -> btn_level, btn_press and cnt unchanged.
- Reset mid-operation: assert rst_n = 0 after 2 qualifying ticks with btn_raw[3] = 1, then release.
  -> All outputs 0 immediately.
  -> After release, btn_press[3] occurs only after 4 new qualifying ticks, and no earlier.
